video_timing_gen: RTL and testbench

Parametrised raster timing generator for the pixel pipeline. It derives a pixel-rate tick from the system clock through a programmable divider. It produces horizontal and vertical counters, sync pulses with configurable polarity, and a video-active flag, plus single-cycle line-start and frame-start strobes, for any display mode set by parameters. It sits between the system clock and the pixel-generation logic, and supersedes the fixed 640x480 sync generator.

---
 rtl/video_timing_gen_if.sv | 48 ++++
 rtl/video_timing_gen.sv | 111 +++++++++++
 tb/tb_video_timing_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator and pixel logic.
// frame_count exists only when VTG_FRAME_COUNT_EN is defined.
interface video_timing_gen_if #(
    parameter int CW = 11
);
    logic          enable;
    logic          tick;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;
`ifdef VTG_FRAME_COUNT_EN
    logic [15:0]   frame_count;
`endif

    modport master (
        input  enable,
        output tick,
        output pixel_x,
        output pixel_y,
        output hsync,
        output vsync,
        output video_on,
        output line_start,
        output frame_start
`ifdef VTG_FRAME_COUNT_EN
        , output frame_count
`endif
    );

    modport slave (
        output enable,
        input  tick,
        input  pixel_x,
        input  pixel_y,
        input  hsync,
        input  vsync,
        input  video_on,
        input  line_start,
        input  frame_start
`ifdef VTG_FRAME_COUNT_EN
        , input frame_count
`endif
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with programmable pixel-tick divider.
// Define VTG_FRAME_COUNT_EN to add the 16-bit frame_count output.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input logic                clk,
    input logic                reset_n,
    video_timing_gen_if.master vt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]    div;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          on_nxt;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;

    assign tick = vt.enable && (div == DIV_LAST);

    // Sync/active flags are decoded from the next counter values so they
    // register on the same edge as the counters themselves.
    always_comb begin
        h_wrap = tick && (h == H_LAST);
        v_wrap = h_wrap && (v == V_LAST);
        h_nxt  = h;
        v_nxt  = v;
        if (tick) h_nxt = h_wrap ? '0 : h + CW'(1);
        if (h_wrap) v_nxt = v_wrap ? '0 : v + CW'(1);
        hs_nxt = (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
        vs_nxt = (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
        on_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (vt.enable) begin
            div         <= (div == DIV_LAST) ? '0 : div + 4'd1;
            h           <= h_nxt;
            v           <= v_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            video_on    <= on_nxt;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    assign vt.tick        = tick;
    assign vt.pixel_x     = h;
    assign vt.pixel_y     = v;
    assign vt.hsync       = hsync;
    assign vt.vsync       = vsync;
    assign vt.video_on    = video_on;
    assign vt.line_start  = line_start;
    assign vt.frame_start = frame_start;

`ifdef VTG_FRAME_COUNT_EN
    logic [15:0] frame_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (v_wrap) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign vt.frame_count = frame_count;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench for video_timing_gen using two display modes.
// Reference model tracks a linear pixel index per frame plus divider phase.
module tb_video_timing_gen;
  localparam int CW = 11;

  localparam int HA [2] = '{8, 16};
  localparam int HF [2] = '{2, 4};
  localparam int HS [2] = '{3, 6};
  localparam int HB [2] = '{3, 4};
  localparam int VA [2] = '{4, 6};
  localparam int VF [2] = '{1, 2};
  localparam int VS [2] = '{1, 2};
  localparam int VB [2] = '{1, 2};
  localparam int CD [2] = '{1, 4};
  localparam bit HP [2] = '{1'b1, 1'b0};
  localparam bit VP [2] = '{1'b0, 1'b1};

  typedef struct packed {
    logic          tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          von;
    logic          ls;
    logic          fs;
    logic [15:0]   fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(CW)) bus_a ();
  video_timing_gen_if #(.CW(CW)) bus_b ();

  video_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
    .CLK_DIV(CD[0]), .HS_POL(HP[0]), .VS_POL(VP[0]), .CW(CW)
  ) dut_a (
    .clk(clk),
    .reset_n(reset_n),
    .vt(bus_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .CLK_DIV(CD[1]), .HS_POL(HP[1]), .VS_POL(VP[1]), .CW(CW)
  ) dut_b (
    .clk(clk),
    .reset_n(reset_n),
    .vt(bus_b)
  );

  int   p [2];
  int   ph [2];
  obs_t r [2];
  obs_t q0 [$];
  obs_t q1 [$];

  function automatic int htot(int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int vtot(int d);
    return VA[d] + VF[d] + VS[d] + VB[d];
  endfunction

  function automatic obs_t rst_obs(int d, bit en);
    obs_t o;
    o = '0;
    o.hs = ~HP[d];
    o.vs = ~VP[d];
    o.tick = en && (CD[d] == 1);
    return o;
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o.tick = bus_a.tick;
    o.x = bus_a.pixel_x;
    o.y = bus_a.pixel_y;
    o.hs = bus_a.hsync;
    o.vs = bus_a.vsync;
    o.von = bus_a.video_on;
    o.ls = bus_a.line_start;
    o.fs = bus_a.frame_start;
`ifdef VTG_FRAME_COUNT_EN
    o.fc = bus_a.frame_count;
`else
    o.fc = '0;
`endif
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.tick = bus_b.tick;
    o.x = bus_b.pixel_x;
    o.y = bus_b.pixel_y;
    o.hs = bus_b.hsync;
    o.vs = bus_b.vsync;
    o.von = bus_b.video_on;
    o.ls = bus_b.line_start;
    o.fs = bus_b.frame_start;
`ifdef VTG_FRAME_COUNT_EN
    o.fc = bus_b.frame_count;
`else
    o.fc = '0;
`endif
    return o;
  endfunction

  task automatic compare(string tag, int d, obs_t got, obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got x=%0d y=%0d tick=%b hs=%b vs=%b on=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d tick=%b hs=%b vs=%b on=%b ls=%b fs=%b fc=%0d",
               tag, d, $time,
               got.x, got.y, got.tick, got.hs, got.vs, got.von, got.ls, got.fs, got.fc,
               want.x, want.y, want.tick, want.hs, want.vs, want.von, want.ls, want.fs, want.fc);
    end
  endtask

  // Advance the reference by one clock edge and queue the post-edge view.
  task automatic model_edge(int d, bit en, bit rst);
    int   ht;
    int   x;
    int   y;
    bit   t;
    obs_t e;
    ht = htot(d);
    if (!rst) begin
      p[d] = 0;
      ph[d] = 0;
      r[d] = rst_obs(d, 1'b0);
    end else if (en) begin
      t = (ph[d] == CD[d] - 1);
      ph[d] = (ph[d] + 1) % CD[d];
      if (t) p[d] = (p[d] + 1) % (ht * vtot(d));
      x = p[d] % ht;
      y = p[d] / ht;
      r[d].hs = (x >= HA[d] + HF[d] && x < HA[d] + HF[d] + HS[d]) ? HP[d] : ~HP[d];
      r[d].vs = (y >= VA[d] + VF[d] && y < VA[d] + VF[d] + VS[d]) ? VP[d] : ~VP[d];
      r[d].von = (x < HA[d]) && (y < VA[d]);
      r[d].ls = t && (x == 0);
      r[d].fs = t && (p[d] == 0);
      if (r[d].fs) r[d].fc = r[d].fc + 16'd1;
    end
    e = r[d];
    e.x = CW'(p[d] % ht);
    e.y = CW'(p[d] / ht);
    e.tick = en && (ph[d] == CD[d] - 1);
`ifndef VTG_FRAME_COUNT_EN
    e.fc = '0;
`endif
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step(input bit en, input bit rst);
    @(negedge clk);
    bus_a.enable = en;
    bus_b.enable = en;
    if (!rst && reset_n) begin
      #2 reset_n = 1'b0;
      #1;
      compare("async_rst", 0, sample_a(), rst_obs(0, en));
      compare("async_rst", 1, sample_b(), rst_obs(1, en));
    end
    reset_n = rst;
    for (int d = 0; d < 2; d++) model_edge(d, en, rst);
    running = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow dut0 got empty queue want entry");
        end else begin
          compare("sb", 0, sample_a(), q0.pop_front());
        end
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow dut1 got empty queue want entry");
        end else begin
          compare("sb", 1, sample_b(), q1.pop_front());
        end
      end
    end
  end

  initial begin
    bit en;
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    compare("por", 0, sample_a(), rst_obs(0, 1'b0));
    compare("por", 1, sample_b(), rst_obs(1, 1'b0));

    repeat (10) step(1'b0, 1'b0);
    repeat (336) step(1'b1, 1'b1);
`ifdef VTG_FRAME_COUNT_EN
    @(posedge clk);
    #2;
    checks++;
    if (bus_a.frame_count !== 16'd3) begin
      errors++;
      $display("FAIL fc_336 got %0d want 3", bus_a.frame_count);
    end
`endif

    repeat (50) step(1'b0, 1'b1);
    repeat (40) step(1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat (50) step(1'b0, 1'b1);
      end
      en = ($urandom_range(0, 7) != 0);
      step(en, 1'b1);
    end

    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      step(en, 1'b1);
    end
    repeat (1500) step(1'b1, 1'b1);

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d left want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
